wishbone_master: RTL and testbench

Bus-master stage sitting directly upstream of `wishbone_slave` in the SD host datapath. Accepts single read/write requests from the host-side controller through a valid/ready port, buffers them in a small FIFO, and issues one Wishbone classic-cycle transaction at a time to the slave. Returns each result (read data or completion) with an error flag when the slave fails to acknowledge within a timeout.

---
 rtl/wishbone_master_pkg.sv | 21 ++
 rtl/wb_req_fifo.sv | 54 +++++
 rtl/wishbone_master.sv | 109 ++++++++++
 tb/tb_wishbone_master.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/wishbone_master_pkg.sv
// Shared definitions for the Wishbone master: FSM encoding and request-record layout.
package wishbone_master_pkg;

  typedef enum logic [1:0] {StIdle, StStrobe, StRelease} wb_state_e;

  localparam int unsigned DataWDefault = 64;

  // Request record layout: {we, adr, data[DATA_W-1:0]}
  function automatic int unsigned req_width(int unsigned data_w);
    return data_w + 2;
  endfunction

  function automatic int unsigned adr_offset(int unsigned data_w);
    return data_w;
  endfunction

  function automatic int unsigned we_offset(int unsigned data_w);
    return data_w + 1;
  endfunction

endpackage

// File: rtl/wb_req_fifo.sv
// Synchronous request FIFO with async reset; head entry is visible on rdata while not empty.
module wb_req_fifo #(
  parameter int unsigned Width = 66,
  parameter int unsigned Depth = 4,
  localparam int unsigned PtrW = $clog2(Depth),
  localparam int unsigned CntW = PtrW + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [Width-1:0] wdata,
  output logic [Width-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CntW-1:0]  count
);

  logic [Width-1:0] mem [Depth];
  logic [PtrW-1:0]  wr_ptr;
  logic [PtrW-1:0]  rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CntW'(Depth));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Depth is a power of two, so pointers wrap naturally.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop) begin
        count <= count + 1'b1;
      end else if (do_pop && !do_push) begin
        count <= count - 1'b1;
      end
    end
  end

endmodule

// File: rtl/wishbone_master.sv
// Queues host requests and issues them one at a time as Wishbone classic cycles with timeout.
module wishbone_master
  import wishbone_master_pkg::*;
#(
  parameter int unsigned DATA_W     = DataWDefault,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic              req_adr,
  input  logic [DATA_W-1:0] req_data,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_error,
  output logic              we_o,
  output logic              adr_o,
  output logic              strobe_o,
  output logic [DATA_W-1:0] wb_data_o,
  input  logic [DATA_W-1:0] wb_data_i,
  input  logic              ack_i,
  output logic              busy
);

  localparam int unsigned ReqW   = req_width(DATA_W);
  localparam int unsigned AdrOff = adr_offset(DATA_W);
  localparam int unsigned WeOff  = we_offset(DATA_W);
  localparam int unsigned CntW   = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned TmrW   = $clog2(TIMEOUT);

  wb_state_e         state;
  logic [TmrW-1:0]   timer;
  logic [ReqW-1:0]   head;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CntW-1:0]   fifo_count;
  logic              pop;

  assign req_ready = (fifo_count != CntW'(FIFO_DEPTH));
  assign pop       = (state == StIdle) && !fifo_empty;
  assign busy      = !fifo_empty || (state != StIdle);

  wb_req_fifo #(
    .Width (ReqW),
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (req_valid && !fifo_full),
    .pop   (pop),
    .wdata ({req_we, req_adr, req_data}),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= StIdle;
      timer     <= '0;
      strobe_o  <= 1'b0;
      we_o      <= 1'b0;
      adr_o     <= 1'b0;
      wb_data_o <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_error <= 1'b0;
    end else begin
      unique case (state)
        StIdle: begin
          rsp_valid <= 1'b0;
          if (!fifo_empty) begin
            we_o      <= head[WeOff];
            adr_o     <= head[AdrOff];
            wb_data_o <= head[DATA_W-1:0];
            strobe_o  <= 1'b1;
            timer     <= '0;
            state     <= StStrobe;
          end
        end
        StStrobe: begin
          // Ack takes priority over a timeout expiring on the same edge.
          if (ack_i || timer == TmrW'(TIMEOUT - 1)) begin
            rsp_data  <= (ack_i && !we_o) ? wb_data_i : '0;
            rsp_error <= !ack_i;
            rsp_valid <= 1'b1;
            strobe_o  <= 1'b0;
            we_o      <= 1'b0;
            adr_o     <= 1'b0;
            wb_data_o <= '0;
            state     <= StRelease;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        StRelease: begin
          rsp_valid <= 1'b0;
          state     <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_wishbone_master.sv
// Directed and randomized checks of wishbone_master against a per-request expectation model.
module tb_wishbone_master;

  localparam int Timeout = 16;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic        req_adr = 1'b0;
  logic [63:0] req_data = '0;
  logic        rsp_valid;
  logic [63:0] rsp_data;
  logic        rsp_error;
  logic        we_o;
  logic        adr_o;
  logic        strobe_o;
  logic [63:0] wb_data_o;
  logic [63:0] wb_data_i = '0;
  logic        ack_i = 1'b0;
  logic        busy;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic        we;
    logic        adr;
    logic [63:0] data;
    int          ack_at;  // strobe cycle on which the slave acks; 0 = never
    logic [63:0] rdata;
  } plan_t;

  plan_t plan_q[$];
  plan_t cur;
  int    cyc = 0;
  int    low_cnt = 0;
  bit    in_txn = 0;
  bit    seen_txn = 0;

  wishbone_master #(
    .DATA_W     (64),
    .FIFO_DEPTH (4),
    .TIMEOUT    (Timeout)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_adr   (req_adr),
    .req_data  (req_data),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_error (rsp_error),
    .we_o      (we_o),
    .adr_o     (adr_o),
    .strobe_o  (strobe_o),
    .wb_data_o (wb_data_o),
    .wb_data_i (wb_data_i),
    .ack_i     (ack_i),
    .busy      (busy)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Slave model and response checker: expected outcome of each request follows from its plan.
  always @(negedge clock) begin
    int  exp_len;
    bit  exp_err;
    bit  falling;
    if (reset) begin
      in_txn   = 0;
      seen_txn = 0;
      cyc      = 0;
      ack_i    = 1'b0;
    end else begin
      falling = !strobe_o && in_txn;
      if (!falling) chk("rsp_valid_quiet", {63'd0, rsp_valid}, 64'd0);
      if (strobe_o) begin
        if (!in_txn) begin
          if (seen_txn) chk("gap_ge_2", {63'd0, low_cnt >= 2}, 64'd1);
          chk("txn_has_plan", {63'd0, plan_q.size() > 0}, 64'd1);
          if (plan_q.size() > 0) cur = plan_q.pop_front();
          else cur = '{we: 1'b0, adr: 1'b0, data: '0, ack_at: 0, rdata: '0};
          in_txn = 1;
          cyc    = 0;
        end
        cyc++;
        chk("bus_we", {63'd0, we_o}, {63'd0, cur.we});
        chk("bus_adr", {63'd0, adr_o}, {63'd0, cur.adr});
        if (cur.we) chk("bus_data", wb_data_o, cur.data);
        ack_i     = (cur.ack_at == cyc);
        wb_data_i = ack_i ? cur.rdata : {$urandom, $urandom};
      end else begin
        // Stray acks while not strobing must have no effect.
        ack_i     = ($urandom_range(0, 3) == 0);
        wb_data_i = {$urandom, $urandom};
        if (falling) begin
          exp_err = !(cur.ack_at >= 1 && cur.ack_at <= Timeout);
          exp_len = exp_err ? Timeout : cur.ack_at;
          chk("strobe_len", 64'(cyc), 64'(exp_len));
          chk("rsp_valid", {63'd0, rsp_valid}, 64'd1);
          chk("rsp_error", {63'd0, rsp_error}, {63'd0, exp_err});
          chk("rsp_data", rsp_data, (!cur.we && !exp_err) ? cur.rdata : 64'd0);
          chk("release_bus", {wb_data_o[61:0], we_o, adr_o}, 64'd0);
          in_txn   = 0;
          seen_txn = 1;
          low_cnt  = 0;
        end
        low_cnt++;
      end
    end
  end

  task automatic push(input logic we, input logic adr, input logic [63:0] data,
                      input int ack_at, input logic [63:0] rdata);
    bit ok = 0;
    @(negedge clock);
    req_valid = 1'b1;
    req_we    = we;
    req_adr   = adr;
    req_data  = data;
    for (int i = 0; i < 400; i++) begin
      if (req_ready) begin
        ok = 1;
        break;
      end
      @(negedge clock);
    end
    if (ok) begin
      plan_q.push_back('{we: we, adr: adr, data: data, ack_at: ack_at, rdata: rdata});
      @(posedge clock);
      #1;
    end
    req_valid = 1'b0;
    if (!ok) chk("push_timeout", {63'd0, ok}, 64'd1);
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int i = 0; i < 800; i++) begin
      @(negedge clock);
      if (!busy && !in_txn && plan_q.size() == 0) begin
        ok = 1;
        break;
      end
    end
    chk("idle_reached", {63'd0, ok}, 64'd1);
    repeat (2) @(negedge clock);
  endtask

  task automatic wait_strobe();
    bit ok = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (strobe_o) begin
        ok = 1;
        break;
      end
    end
    chk("strobe_seen", {63'd0, ok}, 64'd1);
  endtask

  initial begin
    logic [63:0] d;
    int          a;
    int          r;

    // Reset state
    repeat (3) @(negedge clock);
    chk("rst_req_ready", {63'd0, req_ready}, 64'd1);
    chk("rst_strobe", {63'd0, strobe_o}, 64'd0);
    chk("rst_rsp", {rsp_data[61:0], rsp_valid, rsp_error}, 64'd0);
    chk("rst_bus", {wb_data_o[61:0], we_o, adr_o}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    reset = 1'b0;
    repeat (2) @(negedge clock);

    // Single write, acked on 2nd strobe cycle; strobe rises one edge after the push
    push(1'b1, 1'b1, 64'h0000_0000_0000_00A5, 2, 64'h1234);
    chk("push_to_strobe_n", {63'd0, strobe_o}, 64'd0);
    chk("busy_after_push", {63'd0, busy}, 64'd1);
    @(posedge clock);
    #1;
    chk("push_to_strobe_n1", {63'd0, strobe_o}, 64'd1);
    wait_idle();

    // Single read
    push(1'b0, 1'b0, {$urandom, $urandom}, 1, 64'hDEAD_BEEF_CAFE_F00D);
    wait_idle();

    // Back-to-back: fill FIFO behind a slow transaction, then a 5th request must wait
    push(1'b1, 1'b0, 64'h11, 12, '0);
    wait_strobe();
    for (int i = 0; i < 4; i++) push(i[0], i[1], {$urandom, $urandom}, 1, {$urandom, $urandom});
    @(negedge clock);
    chk("full_not_ready", {63'd0, req_ready}, 64'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      req_valid = 1'b1;
      req_we    = 1'b1;
      req_data  = 64'hBAD0_BAD0_BAD0_BAD0;
      chk("full_hold", {63'd0, req_ready}, 64'd0);
    end
    push(1'b0, 1'b1, 64'h55, 1, 64'hA5A5_0000_FFFF_1234);
    wait_idle();

    // Timeout followed by a normal request
    push(1'b1, 1'b1, 64'h77, 0, '0);
    push(1'b0, 1'b1, 64'h0, 3, 64'h0F0F_0F0F_F0F0_F0F0);
    wait_idle();

    // Ack on the last permitted strobe cycle beats the timeout
    push(1'b0, 1'b0, 64'h0, Timeout, 64'hC011_1DE0_0000_0001);
    wait_idle();

    // Randomized traffic
    for (int n = 0; n < 24; n++) begin
      r = $urandom_range(0, 9);
      if (r == 0) a = 0;
      else if (r == 1) a = Timeout;
      else a = $urandom_range(1, 5);
      d = {$urandom, $urandom};
      push(1'($urandom), 1'($urandom), d, a, {$urandom, $urandom});
      repeat ($urandom_range(0, 3)) @(negedge clock);
    end
    wait_idle();

    // Reset while strobing with three requests queued
    push(1'b1, 1'b0, 64'h1, 0, '0);
    wait_strobe();
    for (int i = 0; i < 3; i++) push(1'b0, 1'b1, 64'h2, 0, '0);
    repeat (2) @(negedge clock);
    #2;
    reset = 1'b1;
    #1;
    chk("async_strobe_drop", {63'd0, strobe_o}, 64'd0);
    chk("async_busy", {63'd0, busy}, 64'd0);
    chk("async_req_ready", {63'd0, req_ready}, 64'd1);
    chk("async_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    plan_q.delete();
    repeat (2) @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      chk("post_rst_strobe", {63'd0, strobe_o}, 64'd0);
      chk("post_rst_busy", {63'd0, busy}, 64'd0);
    end
    push(1'b0, 1'b0, 64'h0, 2, 64'h0BAD_CAFE_0000_0042);
    wait_idle();

    chk("plan_drained", 64'(plan_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
